// File: rtl/sequence_player.sv
// Replays recorded note-gate words from the sequence RAM at a fixed tempo.
// Each step is fetched, held for STEP_CYCLES and then forced silent for GAP_CYCLES.
module sequence_player #(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int NOTE_W      = 10,
  parameter int STEP_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 250_000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [NOTE_W-1:0] mem_rdata,
  output logic [NOTE_W-1:0] note_gates,
  output logic              playing,
  output logic              done,
  output logic              wrap
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_HOLD, S_GAP} state_t;

  localparam logic [31:0]     STEP_LOAD = 32'(STEP_CYCLES - 1);
  localparam logic [31:0]     GAP_LOAD  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_LEN   = (ADDR_W + 1)'(1);

  state_t              state_reg, state_next;
  logic [31:0]         cnt_reg, cnt_next;
  logic [ADDR_W:0]     step_reg, step_next;
  logic [ADDR_W:0]     last_reg, last_next;
  logic                play_q_reg;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [NOTE_W-1:0]   note_gates_reg, note_gates_next;
  logic                done_reg, done_next;
  logic                wrap_reg, wrap_next;

  logic                play_rise;
  logic [ADDR_W:0]     len_eff;
  logic                step_end;
  logic                seq_end;

  assign play_rise = play & ~play_q_reg;
  assign len_eff   = (length > DEPTH_LEN) ? DEPTH_LEN : length;
  assign seq_end   = step_end && (step_reg >= last_reg);

  // play_q resets high so a play level held through reset release is not an edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      step_reg       <= '0;
      last_reg       <= '0;
      play_q_reg     <= 1'b1;
      mem_addr_reg   <= '0;
      note_gates_reg <= '0;
      done_reg       <= 1'b0;
      wrap_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      step_reg       <= step_next;
      last_reg       <= last_next;
      play_q_reg     <= play;
      mem_addr_reg   <= mem_addr_next;
      note_gates_reg <= note_gates_next;
      done_reg       <= done_next;
      wrap_reg       <= wrap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    step_next  = step_reg;
    last_next  = last_reg;
    step_end   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (play_rise && !stop && len_eff != '0) begin
          state_next = S_FETCH;
          step_next  = '0;
          last_next  = len_eff - ONE_LEN;
        end
      end
      S_FETCH: state_next = S_LATCH;
      S_LATCH: begin
        state_next = S_HOLD;
        cnt_next   = STEP_LOAD;
      end
      S_HOLD: begin
        if (cnt_reg == '0) begin
          if (GAP_CYCLES == 0) begin
            step_end = 1'b1;
          end else begin
            state_next = S_GAP;
            cnt_next   = GAP_LOAD;
          end
        end else begin
          cnt_next = cnt_reg - 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_reg == '0) step_end = 1'b1;
        else               cnt_next = cnt_reg - 32'd1;
      end
      default: state_next = S_IDLE;
    endcase

    // End-of-step decision folded into the last HOLD/GAP cycle
    if (step_end) begin
      if (step_reg < last_reg) begin
        step_next  = step_reg + ONE_LEN;
        state_next = S_FETCH;
      end else if (loop) begin
        step_next  = '0;
        state_next = S_FETCH;
      end else begin
        state_next = S_IDLE;
      end
    end

    if (stop && state_reg != S_IDLE) state_next = S_IDLE;
  end

  always_comb begin
    mem_addr_next   = (state_next == S_FETCH) ? step_next[ADDR_W-1:0] : mem_addr_reg;
    note_gates_next = '0;
    if (state_next == S_HOLD)
      note_gates_next = (state_reg == S_LATCH) ? mem_rdata : note_gates_reg;
    done_next = !stop && ((state_reg == S_IDLE && play_rise && len_eff == '0) ||
                          (seq_end && !loop));
    wrap_next = !stop && seq_end && loop;
  end

  assign mem_addr   = mem_addr_reg;
  assign note_gates = note_gates_reg;
  assign playing    = (state_reg != S_IDLE);
  assign done       = done_reg;
  assign wrap       = wrap_reg;

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench for sequence_player: expected per-cycle outputs are derived
// from the step timing formula, queued when a scenario starts and popped each cycle.
module tb_sequence_player;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 5;
  localparam int NOTE_W = 10;
  localparam int STEP_C = 4;
  localparam int GAP_C  = 2;
  localparam int PERIOD = STEP_C + GAP_C + 2;

  logic              clock;
  logic              resetn;
  logic              play;
  logic              stop;
  logic              loop;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] mem_addr;
  logic [NOTE_W-1:0] mem_rdata;
  logic [NOTE_W-1:0] note_gates;
  logic              playing;
  logic              done;
  logic              wrap;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NOTE_W-1:0] note;
    logic [ADDR_W-1:0] addr;
    logic              playing;
    logic              done;
    logic              wrap;
  } exp_t;

  exp_t sb_q[$];
  logic [NOTE_W-1:0] ram [0:31];
  int max_addr;

  sequence_player #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W),
    .STEP_CYCLES(STEP_C), .GAP_CYCLES(GAP_C)
  ) dut (
    .clock(clock), .resetn(resetn), .play(play), .stop(stop), .loop(loop),
    .length(length), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .note_gates(note_gates), .playing(playing), .done(done), .wrap(wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) mem_rdata <= ram[mem_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected output after edge E(i), built from the step period formula
  function automatic exp_t expect_at(int i, int n, int total, int stop_at);
    exp_t e;
    int k;
    int r;
    e.note = '0; e.addr = '0; e.playing = 1'b0; e.done = 1'b0; e.wrap = 1'b0;
    if (stop_at > 0 && i >= stop_at) return e;
    if (i < total) begin
      k = i / PERIOD;
      r = i % PERIOD;
      e.playing = 1'b1;
      e.addr    = ADDR_W'(k % n);
      if (r >= 2 && r <= 2 + STEP_C - 1) e.note = NOTE_W'(1 << (k % n));
      e.wrap = (i > 0) && (i % (n * PERIOD) == 0);
    end else begin
      e.done = (i == total);
    end
    return e;
  endfunction

  task automatic run_scenario(input string name, input int len, input bit loop_init,
                              input int loop_drop_at, input int stop_at, input int replay_at);
    int n;
    int wraps;
    int total;
    int last_i;
    exp_t e;
    n = (len > DEPTH) ? DEPTH : len;
    wraps = 0;
    if (loop_init && n > 0)
      while ((wraps + 1) * n * PERIOD <= loop_drop_at) wraps++;
    total  = n * (wraps + 1) * PERIOD;
    last_i = (stop_at > 0) ? stop_at + 3 : total + 2;
    for (int i = 0; i <= last_i; i++) sb_q.push_back(expect_at(i, n, total, stop_at));
    max_addr = 0;

    @(negedge clock);
    length = (ADDR_W + 1)'(len);
    loop   = loop_init;
    play   = 1'b1;
    for (int i = 0; i <= last_i; i++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      check_val($sformatf("%s_note@E%0d", name, i), 32'(note_gates), 32'(e.note));
      check_val($sformatf("%s_playing@E%0d", name, i), 32'(playing), 32'(e.playing));
      check_val($sformatf("%s_done@E%0d", name, i), 32'(done), 32'(e.done));
      check_val($sformatf("%s_wrap@E%0d", name, i), 32'(wrap), 32'(e.wrap));
      if (e.playing) begin
        check_val($sformatf("%s_addr@E%0d", name, i), 32'(mem_addr), 32'(e.addr));
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
      end
      if (i == 1) play = 1'b0;
      if (replay_at > 0 && i == replay_at - 1) play = 1'b1;
      if (replay_at > 0 && i == replay_at + 1) play = 1'b0;
      if (i == loop_drop_at) loop = 1'b0;
      if (stop_at > 0 && i == stop_at - 1) stop = 1'b1;
    end
    $display("scenario %s len=%0d loop=%0b steps=%0d done", name, len, loop_init, n * (wraps + 1));
    play = 1'b0;
    stop = 1'b0;
    loop = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    for (int a = 0; a < 32; a++) ram[a] = (a < DEPTH) ? NOTE_W'(1 << a) : '1;
    resetn = 1'b0; play = 1'b0; stop = 1'b0; loop = 1'b0; length = '0;
    repeat (3) @(negedge clock);
    check_val("rst_note", 32'(note_gates), 0);
    check_val("rst_addr", 32'(mem_addr), 0);
    check_val("rst_playing", 32'(playing), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_wrap", 32'(wrap), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    run_scenario("basic", 3, 1'b0, -1, 0, 0);
    run_scenario("loop", 2, 1'b1, 40, 0, 0);
    run_scenario("loop_drop", 2, 1'b1, 20, 0, 0);
    run_scenario("stop", 3, 1'b0, -1, 4, 0);
    run_scenario("restart", 3, 1'b0, -1, 0, 0);
    run_scenario("len0", 0, 1'b0, -1, 0, 0);
    run_scenario("len12", 12, 1'b0, -1, 0, 0);
    check_val("len12_max_addr", 32'(max_addr), 7);
    run_scenario("replay", 3, 1'b0, -1, 0, 5);

    // Asynchronous reset in the middle of a held step
    length = 6'd3;
    play   = 1'b1;
    repeat (4) @(posedge clock);
    #2;
    check_val("arst_pre_playing", 32'(playing), 1);
    resetn = 1'b0;
    #1;
    check_val("arst_note", 32'(note_gates), 0);
    check_val("arst_addr", 32'(mem_addr), 0);
    check_val("arst_playing", 32'(playing), 0);
    check_val("arst_done", 32'(done), 0);
    check_val("arst_wrap", 32'(wrap), 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_val($sformatf("arst_held_playing%0d", i), 32'(playing), 0);
      check_val($sformatf("arst_held_done%0d", i), 32'(done), 0);
    end
    $display("scenario async_reset done");
    play = 1'b0;
    repeat (2) @(negedge clock);
    run_scenario("after_rst", 3, 1'b0, -1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
# sequence_player

Read-side counterpart to the note-sequence recorder. It reads recorded 10-bit note-gate words from the sequence RAM, one word per step, and replays them as `note_gates` at a fixed tempo. Its output feeds the per-note wave generators in place of the live switch gates. It sequences RAM reads, per-step hold and gap timing, looping, and stop/abort.

## Interface
- `DEPTH`, 32: RAM entries; valid step indices are 0..DEPTH-1.
- `ADDR_W`, 5: RAM address width; DEPTH ≤ 2^ADDR_W.
- `NOTE_W`, 10: gate word width.
- `STEP_CYCLES`, 12_500_000: clocks each word is held on `note_gates` (0.25 s at 50 MHz). Must be ≥1.
- `GAP_CYCLES`, 250_000: forced all-off clocks after each step, so repeated notes retrigger. 0 means no gap.
- `clock` in 1: system clock (CLOCK_50).
- `resetn` in 1: reset, asynchronous, active-low.
- `play` in 1: level start request (from inverted KEY). Acts on its rising edge only.
- `stop` in 1: level abort; has priority over `play`.
- `loop` in 1: at the end of a sequence, wrap to step 0 instead of finishing. Sampled at each end-of-sequence.
- `length` in ADDR_W+1: number of recorded steps. Sampled on the play rising edge.
- `mem_addr` out ADDR_W: RAM read address, registered.
- `mem_rdata` in NOTE_W: RAM read data, valid 1 cycle after `mem_addr`.
- `note_gates` out NOTE_W: replayed gates, registered.
- `playing` out 1: high while the FSM is not IDLE.
- `done` out 1: one-cycle pulse when a non-looping sequence completes.
- `wrap` out 1: one-cycle pulse when a looping sequence wraps to step 0.

## Operation
- States:
  - IDLE → FETCH on a `play` rising edge with length ≠ 0.
  - FETCH → LATCH.
  - LATCH → HOLD, capturing `note_gates <= mem_rdata`.
  - HOLD → GAP after STEP_CYCLES, or → ENDCHK directly if GAP_CYCLES=0.
  - GAP → ENDCHK after GAP_CYCLES.
  - ENDCHK is combinational within the last GAP/HOLD cycle, not a separate state:
    - if step < last: step++, `mem_addr` = step, go to FETCH;
    - else if `loop`: step=0, `wrap`=1, go to FETCH;
    - else: IDLE, `done`=1.
- Effective length = min(`length`, DEPTH).
- Length 0 on a play edge: stay in IDLE, pulse `done` for 1 cycle, `playing` stays 0.
- Rising-edge detect: `play_q` register. Rise = `play & ~play_q`.
- Rising edges while `playing` are ignored; no restart.
- `stop` high in any non-IDLE state: at the next edge go to IDLE, with `note_gates`=0 and `playing`=0. `done` and `wrap` stay low.
- `note_gates` is 0 in IDLE, FETCH, LATCH and GAP. It holds the latched word only during HOLD.
- Counters:
  - one down-counter, 32 bits, reused for HOLD and GAP;
  - step index is ADDR_W+1 bits;
  - comparison against effective length − 1.

## Timing
- Reset (async assert) values: `mem_addr`=0, `note_gates`=0, `playing`=0, `done`=0, `wrap`=0, state IDLE, `play_q`=1.
  - Because `play_q` resets to 1, a `play` held through reset release does not start playback.
- Edge E0 samples the `play` rise. Then:
  - FETCH at E0 with `mem_addr`=0 and `playing`=1;
  - LATCH at E1;
  - word0 on `note_gates` from E2.
- Step period = STEP_CYCLES + GAP_CYCLES + 2 clocks. Word k appears at E(2 + k·period).
- `done` and `wrap` are asserted for exactly 1 cycle, on the same edge that leaves the final GAP/HOLD. `playing` falls on that same edge when finishing.
- `stop` and `play` on the same edge: `stop` wins.
- `resetn` asserted mid-operation: all outputs zero immediately, with no clock needed.

## Test plan
Bench parameters: STEP_CYCLES=4, GAP_CYCLES=2, DEPTH=8. RAM model has 1-cycle latency.

- RAM = {0x001, 0x002, 0x004}, length=3, `play` rise at E0:
  - `note_gates` = 0x001 on E2–E5, 0x002 on E10–E13, 0x004 on E18–E21, 0 otherwise;
  - `mem_addr` = 0, 1, 2 at E0, E8, E16;
  - `done`=1 only at E24, and `playing` falls at E24.
- length=2, `loop`=1:
  - `wrap` pulses at E16 and E32;
  - word0 reappears at E18;
  - `done` never asserts;
  - dropping `loop` before E32 gives `done` at E32 instead of `wrap`.
- `stop` at E3 (mid-HOLD): `note_gates`=0 and `playing`=0 from E4; no `done`; a new `play` edge restarts from `mem_addr`=0.
- length=0: `play` edge gives `done` for 1 cycle and `playing`=0. length=12: exactly 8 steps play, with `mem_addr` reaching 7 and never 8.
- `resetn` low at E3 with no clock edge: all outputs 0 within the same cycle. After release with `play` held high there is no start; releasing then re-pressing `play` starts normally.
- Second `play` edge at E5 while playing is ignored; the timing is identical to the first scenario.
